// File: rtl/ft245_fifo_responder_pkg.sv
// Shared constants for the FT245 device-side responder: default geometry and
// the byte shown on the data bus while the RX buffer is empty.
package ft245_fifo_responder_pkg;

    localparam int          FT245_DEPTH      = 16;
    localparam int          FT245_TXE_MARGIN = 2;
    localparam logic [7:0]  FT245_IDLE_DATA  = 8'h00;

endpackage

// File: rtl/param_sync_fifo.sv
// Generic first-word-fall-through buffer: the head entry is always visible on
// popData; push is ignored when full and pop is ignored when empty.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     pushData,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     popData,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int                    AW         = $clog2(DEPTH);
    localparam logic [AW:0]           FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic                  doPush;
    logic                  doPop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == {(AW+1){1'b0}});
    assign doPush  = push & ~full;
    assign doPop   = pop & ~empty;
    assign popData = mem[rdPtr];

    // Storage array; contents need no reset because empty gates every reader.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks occupancy 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= {AW{1'b0}};
            rdPtr <= {AW{1'b0}};
            level <= {(AW+1){1'b0}};
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ft245_fifo_responder.sv
// FTDI-side end of an FT245 synchronous FIFO link: RX buffer feeds the FPGA
// master, TX buffer collects master writes for a host-side stream.
module ft245_fifo_responder
    import ft245_fifo_responder_pkg::*;
#(
    parameter int DEPTH      = FT245_DEPTH,
    parameter int TXE_MARGIN = FT245_TXE_MARGIN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               iHOST_DATA,
    input  logic                     iHOST_VALID,
    output logic                     oHOST_READY,
    output logic [7:0]               oHOST_DATA,
    output logic                     oHOST_VALID,
    input  logic                     iHOST_READY,
    output logic                     oFIFO_RXF_n,
    input  logic                     iFIFO_RD_n,
    output logic [7:0]               oFIFO_DATA,
    output logic                     oFIFO_DATA_EN,
    output logic                     oFIFO_TXE_n,
    input  logic                     iFIFO_WR_n,
    input  logic [7:0]               iFIFO_DATA,
    input  logic                     iFIFO_SIWU_n,
    output logic                     oSEND_IMMEDIATE,
    output logic [$clog2(DEPTH):0]   oRX_LEVEL,
    output logic [$clog2(DEPTH):0]   oTX_LEVEL,
    output logic                     oERR_RD,
    output logic                     oERR_WR
);

    localparam int           LW          = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
    localparam logic [LW-1:0] MARGIN_L   = LW'(TXE_MARGIN);

    logic            rstR;
    logic            siwuR;
    logic [LW-1:0]   rxLevel;
    logic [LW-1:0]   txLevel;
    logic            rxFull;
    logic            rxEmpty;
    logic            txFull;
    logic            txEmpty;
    logic [7:0]      rxHead;
    logic [7:0]      txHead;
    logic            rxPush;
    logic            rxPop;
    logic            txPush;
    logic            txPop;
    logic            txeBlocked;

    // rstR holds the flags in their reset state for the cycle following a reset edge.
    assign txeBlocked  = (DEPTH_L - txLevel) <= MARGIN_L;
    assign oFIFO_RXF_n = rstR | rxEmpty;
    assign oFIFO_TXE_n = rstR | txeBlocked;
    assign oHOST_READY = ~rstR & ~rxFull;
    assign oHOST_VALID = ~rstR & ~txEmpty;
    assign oFIFO_DATA  = rxEmpty ? FT245_IDLE_DATA : rxHead;
    assign oHOST_DATA  = txEmpty ? FT245_IDLE_DATA : txHead;
    assign oRX_LEVEL   = rxLevel;
    assign oTX_LEVEL   = txLevel;

    assign rxPush = iHOST_VALID & oHOST_READY;
    assign rxPop  = ~iFIFO_RD_n & ~oFIFO_RXF_n;
    assign txPush = ~iFIFO_WR_n & ~oFIFO_TXE_n;
    assign txPop  = oHOST_VALID & iHOST_READY;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) rxFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rxPush),
        .pushData (iHOST_DATA),
        .pop      (rxPop),
        .popData  (rxHead),
        .level    (rxLevel),
        .full     (rxFull),
        .empty    (rxEmpty)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) txFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (txPush),
        .pushData (iFIFO_DATA),
        .pop      (txPop),
        .popData  (txHead),
        .level    (txLevel),
        .full     (txFull),
        .empty    (txEmpty)
    );

    // Bus-side registers: data enable, SIWU edge pulse and sticky protocol errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstR            <= 1'b1;
            oFIFO_DATA_EN   <= 1'b0;
            siwuR           <= 1'b1;
            oSEND_IMMEDIATE <= 1'b0;
            oERR_RD         <= 1'b0;
            oERR_WR         <= 1'b0;
        end else begin
            rstR            <= 1'b0;
            oFIFO_DATA_EN   <= ~iFIFO_RD_n;
            siwuR           <= iFIFO_SIWU_n;
            oSEND_IMMEDIATE <= siwuR & ~iFIFO_SIWU_n;
            oERR_RD         <= oERR_RD | (~iFIFO_RD_n & oFIFO_RXF_n);
            oERR_WR         <= oERR_WR | (~iFIFO_WR_n & oFIFO_TXE_n);
        end
    end

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Scoreboard bench for ft245_fifo_responder: drivers queue expected bytes,
// a negedge monitor compares them whenever a pop is about to happen.
module tb_ft245_fifo_responder;

    localparam int DEPTH      = 16;
    localparam int TXE_MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  iHOST_DATA;
    logic        iHOST_VALID;
    logic        oHOST_READY;
    logic [7:0]  oHOST_DATA;
    logic        oHOST_VALID;
    logic        iHOST_READY;
    logic        oFIFO_RXF_n;
    logic        iFIFO_RD_n;
    logic [7:0]  oFIFO_DATA;
    logic        oFIFO_DATA_EN;
    logic        oFIFO_TXE_n;
    logic        iFIFO_WR_n;
    logic [7:0]  iFIFO_DATA;
    logic        iFIFO_SIWU_n;
    logic        oSEND_IMMEDIATE;
    logic [4:0]  oRX_LEVEL;
    logic [4:0]  oTX_LEVEL;
    logic        oERR_RD;
    logic        oERR_WR;

    int          nChecks = 0;
    int          nFail   = 0;
    logic [7:0]  rxExp[$];
    logic [7:0]  txExp[$];
    int          pulses;

    ft245_fifo_responder #(.DEPTH(DEPTH), .TXE_MARGIN(TXE_MARGIN)) dut (
        .clk             (clk),
        .rst             (rst),
        .iHOST_DATA      (iHOST_DATA),
        .iHOST_VALID     (iHOST_VALID),
        .oHOST_READY     (oHOST_READY),
        .oHOST_DATA      (oHOST_DATA),
        .oHOST_VALID     (oHOST_VALID),
        .iHOST_READY     (iHOST_READY),
        .oFIFO_RXF_n     (oFIFO_RXF_n),
        .iFIFO_RD_n      (iFIFO_RD_n),
        .oFIFO_DATA      (oFIFO_DATA),
        .oFIFO_DATA_EN   (oFIFO_DATA_EN),
        .oFIFO_TXE_n     (oFIFO_TXE_n),
        .iFIFO_WR_n      (iFIFO_WR_n),
        .iFIFO_DATA      (iFIFO_DATA),
        .iFIFO_SIWU_n    (iFIFO_SIWU_n),
        .oSEND_IMMEDIATE (oSEND_IMMEDIATE),
        .oRX_LEVEL       (oRX_LEVEL),
        .oTX_LEVEL       (oTX_LEVEL),
        .oERR_RD         (oERR_RD),
        .oERR_WR         (oERR_WR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hostPush(input logic [7:0] d);
        iHOST_VALID = 1'b1;
        iHOST_DATA  = d;
        if (oHOST_READY) rxExp.push_back(d);
        tick();
        iHOST_VALID = 1'b0;
    endtask

    task automatic masterWrite(input logic [7:0] d);
        iFIFO_WR_n = 1'b0;
        iFIFO_DATA = d;
        if (!oFIFO_TXE_n) txExp.push_back(d);
        tick();
        iFIFO_WR_n = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_rxf_n"},   32'(oFIFO_RXF_n),     32'd1);
        check({tag, "_txe_n"},   32'(oFIFO_TXE_n),     32'd1);
        check({tag, "_hready"},  32'(oHOST_READY),     32'd0);
        check({tag, "_hvalid"},  32'(oHOST_VALID),     32'd0);
        check({tag, "_data"},    32'(oFIFO_DATA),      32'h00);
        check({tag, "_data_en"}, 32'(oFIFO_DATA_EN),   32'd0);
        check({tag, "_si"},      32'(oSEND_IMMEDIATE), 32'd0);
        check({tag, "_rxlvl"},   32'(oRX_LEVEL),       32'd0);
        check({tag, "_txlvl"},   32'(oTX_LEVEL),       32'd0);
        check({tag, "_err_rd"},  32'(oERR_RD),         32'd0);
        check({tag, "_err_wr"},  32'(oERR_WR),         32'd0);
    endtask

    // Monitor: a pop happens on the next edge, so the presented byte must be the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (!iFIFO_RD_n && !oFIFO_RXF_n) begin
                if (rxExp.size() == 0) check("rx_unexpected_pop", 32'(oFIFO_DATA), 32'hFFFF_FFFF);
                else                   check("rx_data", 32'(oFIFO_DATA), 32'(rxExp.pop_front()));
            end
            if (oHOST_VALID && iHOST_READY) begin
                if (txExp.size() == 0) check("tx_unexpected_pop", 32'(oHOST_DATA), 32'hFFFF_FFFF);
                else                   check("tx_data", 32'(oHOST_DATA), 32'(txExp.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; iHOST_DATA = 8'h00; iHOST_VALID = 1'b0; iHOST_READY = 1'b0;
        iFIFO_RD_n = 1'b1; iFIFO_WR_n = 1'b1; iFIFO_DATA = 8'h00; iFIFO_SIWU_n = 1'b1;
        repeat (3) tick();
        checkResetState("por");
        rst = 1'b0;
        tick();
        check("rel_rxf_n",  32'(oFIFO_RXF_n), 32'd1);
        check("rel_txe_n",  32'(oFIFO_TXE_n), 32'd0);
        check("rel_hready", 32'(oHOST_READY), 32'd1);
        check("rel_rxlvl",  32'(oRX_LEVEL),   32'd0);
        check("rel_txlvl",  32'(oTX_LEVEL),   32'd0);

        // Two host bytes, then a two-cycle master read.
        hostPush(8'hA5);
        check("rx_first_rxf_n", 32'(oFIFO_RXF_n), 32'd0);
        check("rx_first_data",  32'(oFIFO_DATA),  32'hA5);
        hostPush(8'h3C);
        iFIFO_RD_n = 1'b0;
        tick();
        check("rd_data_en", 32'(oFIFO_DATA_EN), 32'd1);
        tick();
        iFIFO_RD_n = 1'b1;
        check("rd_empty_rxf_n", 32'(oFIFO_RXF_n), 32'd1);
        tick();
        check("rd_no_err",     32'(oERR_RD),       32'd0);
        check("rd_data_en_lo", 32'(oFIFO_DATA_EN), 32'd0);

        // Fill TX to the margin with the host stalled.
        for (int i = 0; i < 14; i++) masterWrite(8'h10 + 8'(i));
        check("tx_txe_hi",  32'(oFIFO_TXE_n), 32'd1);
        check("tx_lvl14",   32'(oTX_LEVEL),   32'd14);
        check("tx_hvalid",  32'(oHOST_VALID), 32'd1);
        check("tx_head",    32'(oHOST_DATA),  32'h10);
        check("tx_err_pre", 32'(oERR_WR),     32'd0);
        masterWrite(8'hEE);
        check("tx_err_wr",  32'(oERR_WR),     32'd1);
        check("tx_dropped", 32'(oTX_LEVEL),   32'd14);
        iHOST_READY = 1'b1;
        repeat (14) tick();
        iHOST_READY = 1'b0;
        check("tx_drained", 32'(oHOST_VALID), 32'd0);
        check("tx_q_empty", 32'(txExp.size()), 32'd0);

        // Fill RX, then stream push+pop across the pointer wrap.
        for (int i = 0; i < 16; i++) hostPush(8'h40 + 8'(i));
        check("rx_full_lvl",   32'(oRX_LEVEL),   32'd16);
        check("rx_full_ready", 32'(oHOST_READY), 32'd0);
        hostPush(8'hDD);
        check("rx_full_drop",  32'(oRX_LEVEL),   32'd16);
        iFIFO_RD_n = 1'b0;
        tick();
        iHOST_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            iHOST_DATA = 8'h80 + 8'(i);
            if (oHOST_READY) rxExp.push_back(iHOST_DATA);
            tick();
            check("rx_stream_lvl", 32'(oRX_LEVEL),   32'd15);
            check("rx_stream_rdy", 32'(oHOST_READY), 32'd1);
        end
        iHOST_VALID = 1'b0;
        repeat (15) tick();
        iFIFO_RD_n = 1'b1;
        check("rx_stream_empty", 32'(oRX_LEVEL),    32'd0);
        check("rx_q_empty",      32'(rxExp.size()), 32'd0);
        check("rx_idle_data",    32'(oFIFO_DATA),   32'h00);
        iFIFO_RD_n = 1'b0;
        tick();
        iFIFO_RD_n = 1'b1;
        check("overread_err", 32'(oERR_RD), 32'd1);

        // SIWU held low: a single pulse.
        pulses = 0;
        iFIFO_SIWU_n = 1'b0;
        tick();
        check("siwu_pulse", 32'(oSEND_IMMEDIATE), 32'd1);
        if (oSEND_IMMEDIATE) pulses++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oSEND_IMMEDIATE) pulses++;
        end
        check("siwu_count", 32'(pulses), 32'd1);
        iFIFO_SIWU_n = 1'b1;
        tick();

        // Reset with both buffers partly full.
        for (int i = 0; i < 5; i++) hostPush(8'hC0 + 8'(i));
        for (int i = 0; i < 5; i++) masterWrite(8'hD0 + 8'(i));
        check("pre_rst_rxlvl", 32'(oRX_LEVEL), 32'd5);
        check("pre_rst_txlvl", 32'(oTX_LEVEL), 32'd5);
        rst = 1'b1;
        tick();
        checkResetState("mid");
        rxExp.delete();
        txExp.delete();
        rst = 1'b0;
        tick();
        check("post_txe_n",  32'(oFIFO_TXE_n), 32'd0);
        check("post_hready", 32'(oHOST_READY), 32'd1);
        iHOST_READY = 1'b1;
        repeat (2) tick();
        check("post_hvalid", 32'(oHOST_VALID), 32'd0);
        check("post_rxf_n",  32'(oFIFO_RXF_n), 32'd1);
        iHOST_READY = 1'b0;
        hostPush(8'h77);
        iFIFO_RD_n = 1'b0;
        tick();
        iFIFO_RD_n = 1'b1;
        masterWrite(8'h99);
        iHOST_READY = 1'b1;
        tick();
        iHOST_READY = 1'b0;
        tick();
        check("final_rx_q", 32'(rxExp.size()), 32'd0);
        check("final_tx_q", 32'(txExp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
